// File: rtl/mosbius_pkg.sv
// Shared types and index helpers for the MOSbius switch-matrix configuration chain.
package mosbius_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        BREAK
    } state_e;

    function automatic int chain_len(input int n_bus, input int n_dev);
        return n_bus * n_dev;
    endfunction

    // Switch for device terminal 'dev' onto bus 'bus' sits at dev*N_BUS + bus in the chain.
    function automatic int sw_idx(input int dev, input int bus, input int n_bus = 5);
        return dev * n_bus + bus;
    endfunction

endpackage

// File: rtl/mosbius_bbm_timer.sv
// Break-before-make countdown: loads a cycle count and flags the final cycle of the interval.
module mosbius_bbm_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == W'(1));

endmodule

// File: rtl/mosbius_cfg_chain.sv
// Double-buffered serial configuration chain for the MOSbius analog switch matrix,
// with frame-length checking, readback of the active configuration and a BBM interval.
module mosbius_cfg_chain
    import mosbius_pkg::*;
#(
    parameter int N_BUS      = 5,
    parameter int N_DEV      = 16,
    parameter int BBM_CYCLES = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             dat_in_i,
    output logic                             dat_out_o,
    output logic [chain_len(N_BUS,N_DEV)-1:0] sw_ctrl_o,
    output logic                             busy_o,
    output logic                             err_o,
    output logic                             cfg_valid_o
);

    localparam int L  = chain_len(N_BUS, N_DEV);
    localparam int CW = $clog2(L + 2);
    localparam int BW = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES + 1) : 1;

    state_e          state_q;
    logic [L-1:0]    sr_q;
    logic [L-1:0]    shadow_q;
    logic [L-1:0]    sw_q;
    logic [CW-1:0]   cnt_q;
    logic            dat_out_q;
    logic            err_q;
    logic            valid_q;
    logic            bbm_load;
    logic            bbm_done;

    assign bbm_load = (state_q == SHIFT) && !enable_i && (cnt_q == CW'(L));

    mosbius_bbm_timer #(
        .W(BW)
    ) u_bbm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (bbm_load),
        .load_val_i (BW'(BBM_CYCLES)),
        .done_o     (bbm_done)
    );

    // The shadow is pushed into the chain on the first bit, so readback costs no extra cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            shadow_q  <= '0;
            sw_q      <= '0;
            cnt_q     <= '0;
            dat_out_q <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        sr_q      <= {shadow_q[L-2:0], dat_in_i};
                        dat_out_q <= shadow_q[L-1];
                        cnt_q     <= CW'(1);
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (enable_i) begin
                        sr_q      <= {sr_q[L-2:0], dat_in_i};
                        dat_out_q <= sr_q[L-1];
                        if (cnt_q != CW'(L + 1)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (cnt_q == CW'(L)) begin
                        shadow_q <= sr_q;
                        err_q    <= 1'b0;
                        if (BBM_CYCLES == 0) begin
                            sw_q    <= sr_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            sw_q    <= '0;
                            state_q <= BREAK;
                        end
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                BREAK: begin
                    if (bbm_done) begin
                        sw_q    <= shadow_q;
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dat_out_o   = dat_out_q;
    assign sw_ctrl_o   = sw_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;
    assign cfg_valid_o = valid_q;

endmodule

// File: tb/tb_mosbius_cfg_chain.sv
// Randomized self-checking bench: a BBM=2 and a BBM=0 build run side by side against a frame-level model.
module tb_mosbius_cfg_chain;

    localparam int NB = 5;
    localparam int ND = 4;
    localparam int L  = NB * ND;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, enA, datA, enB, datB;
    logic         doA, busyA, errA, validA;
    logic         doB, busyB, errB, validB;
    logic [L-1:0] swA, swB;

    mosbius_cfg_chain #(.N_BUS(NB), .N_DEV(ND), .BBM_CYCLES(2)) dutA (
        .clk_i(clk), .rst_i(rst), .enable_i(enA), .dat_in_i(datA),
        .dat_out_o(doA), .sw_ctrl_o(swA), .busy_o(busyA), .err_o(errA), .cfg_valid_o(validA)
    );

    mosbius_cfg_chain #(.N_BUS(NB), .N_DEV(ND), .BBM_CYCLES(0)) dutB (
        .clk_i(clk), .rst_i(rst), .enable_i(enB), .dat_in_i(datB),
        .dat_out_o(doB), .sw_ctrl_o(swB), .busy_o(busyB), .err_o(errB), .cfg_valid_o(validB)
    );

    int checks = 0;
    int passes = 0;

    // Frame-level model: active shadow, applied switches, flags and the last readback bit.
    logic [L-1:0] shA, swMA, shB, swMB;
    logic         errMA, valMA, lastA, errMB, valMB, lastB;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic doReset();
        rst = 1'b1; enA = 1'b0; enB = 1'b0; datA = 1'b0; datB = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("rstSwA", 32'(swA), 0);
        checkOutput("rstFlagsA", {28'd0, doA, busyA, errA, validA}, 0);
        checkOutput("rstSwB", 32'(swB), 0);
        checkOutput("rstFlagsB", {28'd0, doB, busyB, errB, validB}, 0);
        shA = '0; swMA = '0; errMA = 0; valMA = 0; lastA = 0;
        shB = '0; swMB = '0; errMB = 0; valMB = 0; lastB = 0;
    endtask

    // Readback stream is the old shadow MSB first followed by the frame bits themselves.
    task automatic applyStimulus(input int len, input logic [31:0] data, input bit driveB);
        logic qa[$];
        logic qb[$];
        for (int i = L - 1; i >= 0; i--) begin
            qa.push_back(shA[i]);
            qb.push_back(shB[i]);
        end
        for (int i = len - 1; i >= 0; i--) begin
            qa.push_back(data[i]);
            qb.push_back(data[i]);
        end
        for (int i = 0; i < len; i++) begin
            enA = 1'b1; datA = data[len-1-i];
            if (driveB) begin enB = 1'b1; datB = data[len-1-i]; end
            tick();
            checkOutput($sformatf("datOutA[%0d]", i), 32'(doA), 32'(qa[i]));
            if (driveB) checkOutput($sformatf("datOutB[%0d]", i), 32'(doB), 32'(qb[i]));
        end
        checkOutput("busyShiftA", 32'(busyA), 1);
        lastA = qa[len-1];
        if (driveB) lastB = qb[len-1];
    endtask

    task automatic endFrame(input int len, input logic [31:0] data, input bit driveB, input bit holdEnable);
        enA = 1'b0; datA = 1'($urandom); enB = 1'b0; datB = 1'($urandom);
        tick();
        if (len == L) begin
            shA = data[L-1:0]; errMA = 0;
            checkOutput("breakSw0A", 32'(swA), 0);
            checkOutput("breakBusy0A", 32'(busyA), 1);
            checkOutput("goodErrA", 32'(errA), 0);
            if (driveB) begin
                shB = data[L-1:0]; swMB = data[L-1:0]; errMB = 0; valMB = 1;
                checkOutput("noBbmSwB", 32'(swB), 32'(swMB));
                checkOutput("noBbmFlagsB", {29'd0, busyB, errB, validB}, 3'b001);
            end
            if (holdEnable) begin enA = 1'b1; datA = 1'($urandom); end
            tick();
            checkOutput("breakSw1A", 32'(swA), 0);
            checkOutput("breakBusy1A", 32'(busyA), 1);
            checkOutput("breakHoldDoA", 32'(doA), 32'(lastA));
            datA = 1'($urandom);
            tick();
            swMA = data[L-1:0]; valMA = 1;
            checkOutput("appliedSwA", 32'(swA), 32'(swMA));
            checkOutput("appliedFlagsA", {29'd0, busyA, errA, validA}, {29'd0, 1'b0, errMA, valMA});
            checkOutput("holdDoA", 32'(doA), 32'(lastA));
            if (driveB) checkOutput("stableSwB", 32'(swB), 32'(swMB));
        end else begin
            errMA = 1;
            checkOutput("badErrA", 32'(errA), 1);
            checkOutput("badBusyA", 32'(busyA), 0);
            checkOutput("badSwA", 32'(swA), 32'(swMA));
            checkOutput("badValidA", 32'(validA), 32'(valMA));
            checkOutput("holdDoA", 32'(doA), 32'(lastA));
            if (driveB) begin
                errMB = 1;
                checkOutput("badErrB", 32'(errB), 1);
                checkOutput("badSwB", 32'(swB), 32'(swMB));
            end
        end
    endtask

    task automatic frame(input int len, input logic [31:0] data);
        applyStimulus(len, data, 1'b1);
        endFrame(len, data, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        int          len;
        rst = 1'b1; enA = 0; enB = 0; datA = 0; datB = 0;
        tick();
        doReset();

        frame(L, 32'hA5A5A);
        frame(L, 32'h0F0F0);
        frame(L - 1, 32'($urandom) & 32'h7FFFF);
        frame(L + 5, $urandom & 32'h1FFFFFF);
        checkOutput("shadowKeptA", 32'(shA), 32'h0F0F0);
        frame(L, 32'($urandom) & 32'hFFFFF);
        frame(L, 32'(swMA));

        // Enable held through BREAK: the next frame begins on the first IDLE cycle.
        d = $urandom & 32'hFFFFF;
        applyStimulus(L, d, 1'b0);
        endFrame(L, d, 1'b0, 1'b1);
        d = $urandom & 32'hFFFFF;
        applyStimulus(L, d, 1'b0);
        endFrame(L, d, 1'b0, 1'b0);
        frame(L, $urandom & 32'hFFFFF);

        for (int k = 0; k < 10; k++) begin
            len = ($urandom_range(0, 2) != 0) ? L : int'($urandom_range(1, 30));
            frame(len, $urandom & ((len >= 32) ? 32'hFFFFFFFF : ((32'd1 << len) - 1)));
        end

        applyStimulus(10, $urandom & 32'h3FF, 1'b1);
        doReset();
        frame(L, $urandom & 32'hFFFFF);

        d = $urandom & 32'hFFFFF;
        applyStimulus(L, d, 1'b1);
        enA = 1'b0; enB = 1'b0;
        tick();
        checkOutput("inBreakBusyA", 32'(busyA), 1);
        doReset();
        frame(L, $urandom & 32'hFFFFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
